// File: rtl/icache_pkg.sv
// Shared types and constants for the I-cache lookup controller and its LRU array.
// Bank word layout per way: {data[255:0], tag[19:0], valid}.
package icache_pkg;
    localparam int ADDR_W      = 32;
    localparam int SETS        = 256;
    localparam int IDX_W       = 8;
    localparam int LINE_W      = 256;
    localparam int OFF_W       = 5;
    localparam int TAG_W       = 20;
    localparam int WAY_W       = LINE_W + TAG_W + 1;
    localparam int DOUT_W      = 2 * WAY_W;
    localparam int VALID_POS   = 0;
    localparam int TAG_LSB     = 1;
    localparam int DATA_LSB    = TAG_LSB + TAG_W;
    localparam int LINE_ADDR_W = ADDR_W - OFF_W;
    localparam int FLUSH_CTR_W = 9;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP,
        ST_MREQ,
        ST_MWAIT,
        ST_FILL
    } state_t;

    function automatic logic [WAY_W-1:0] way_field(input logic [DOUT_W-1:0] dout, input logic w);
        return w ? dout[DOUT_W-1:WAY_W] : dout[WAY_W-1:0];
    endfunction
endpackage

// File: rtl/icache_plru.sv
// One replacement bit per set; the stored bit names the way to evict next.
// Cleared by reset and at the end of every invalidate sweep.
module icache_plru
    import icache_pkg::*;
(
    input  logic             clka,
    input  logic             rstn,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_way,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_way,
    input  logic             clr
);
    logic [SETS-1:0] lru_q, lru_d;

    always_comb begin
        lru_d = lru_q;
        if (clr) begin
            lru_d = '0;
        end else if (upd_en) begin
            lru_d[upd_idx] = upd_way;
        end
    end

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end

    assign rd_way = lru_q[rd_idx];
endmodule

// File: rtl/icache_lookup_ctrl.sv
// Front-end controller for the 2-way, 256-set I-cache bank: lookup, single-beat refill,
// victim write and the full invalidate sweep.
//   state  | meaning
//   FLUSH  | writing zeros to every (set, way), one per cycle
//   IDLE   | ready for a fetch; issues the bank read on acceptance
//   LOOKUP | bank data back, compare tags
//   RESP   | hold line on resp_data until consumer accepts
//   MREQ   | refill request to memory
//   MWAIT  | waiting for the refill beat
//   FILL   | write victim way, update replacement bit
module icache_lookup_ctrl
    import icache_pkg::*;
(
    input  logic                clka,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [LINE_W-1:0]   resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_resp_valid,
    input  logic [LINE_W-1:0]   mem_resp_data,
    input  logic                flush,
    output logic                flush_busy,
    output logic                sram_ena,
    output logic                sram_wea,
    output logic                sram_wway,
    output logic [IDX_W-1:0]    sram_addr,
    output logic [WAY_W-1:0]    sram_din,
    input  logic [DOUT_W-1:0]   sram_dout
);
    state_t                   state_q, state_d;
    logic [FLUSH_CTR_W-1:0]   flush_ctr_q, flush_ctr_d;
    logic [LINE_ADDR_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]        data_q, data_d;
    logic [1:0]               vld_q, vld_d;
    logic                     flush_pend_q, flush_pend_d;

    logic [IDX_W-1:0]         idx;
    logic [TAG_W-1:0]         tag;
    logic [WAY_W-1:0]         way0, way1;
    logic                     hit0, hit1;
    logic                     lru_way, victim;
    logic                     lru_upd, lru_val, lru_clr;
    logic                     unused_off;

    assign unused_off = ^req_addr[OFF_W-1:0];

    assign idx  = line_q[IDX_W-1:0];
    assign tag  = {1'b0, line_q[LINE_ADDR_W-1:IDX_W]};
    assign way0 = way_field(sram_dout, 1'b0);
    assign way1 = way_field(sram_dout, 1'b1);
    assign hit0 = way0[VALID_POS] && (way0[DATA_LSB-1:TAG_LSB] == tag);
    assign hit1 = way1[VALID_POS] && (way1[DATA_LSB-1:TAG_LSB] == tag);

    // Prefer filling an empty way; fall back to the replacement bit only when both are live.
    assign victim = !vld_q[0] ? 1'b0 : (!vld_q[1] ? 1'b1 : lru_way);

    assign resp_data    = data_q;
    assign mem_req_addr = {line_q, {OFF_W{1'b0}}};

    icache_plru u_plru (
        .clka    (clka),
        .rstn    (rstn),
        .rd_idx  (idx),
        .rd_way  (lru_way),
        .upd_en  (lru_upd),
        .upd_idx (idx),
        .upd_way (lru_val),
        .clr     (lru_clr)
    );

    always_comb begin
        state_d       = state_q;
        flush_ctr_d   = flush_ctr_q;
        line_d        = line_q;
        data_d        = data_q;
        vld_d         = vld_q;
        flush_pend_d  = flush_pend_q | flush;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_req_valid = 1'b0;
        flush_busy    = 1'b0;
        sram_ena      = 1'b0;
        sram_wea      = 1'b0;
        sram_wway     = 1'b0;
        sram_addr     = idx;
        sram_din      = '0;
        lru_upd       = 1'b0;
        lru_val       = 1'b0;
        lru_clr       = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                flush_busy  = 1'b1;
                sram_ena    = 1'b1;
                sram_wea    = 1'b1;
                sram_addr   = flush_ctr_q[FLUSH_CTR_W-1:1];
                sram_wway   = flush_ctr_q[0];
                flush_ctr_d = flush_ctr_q + 9'd1;
                if (&flush_ctr_q) begin
                    state_d = ST_IDLE;
                    lru_clr = 1'b1;
                end
            end
            ST_IDLE: begin
                // A pending invalidate wins over a waiting fetch.
                if (flush_pend_q) begin
                    state_d      = ST_FLUSH;
                    flush_ctr_d  = '0;
                    flush_pend_d = flush;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        sram_ena  = 1'b1;
                        sram_addr = req_addr[IDX_W+OFF_W-1:OFF_W];
                        line_d    = req_addr[ADDR_W-1:OFF_W];
                        state_d   = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                vld_d = {way1[VALID_POS], way0[VALID_POS]};
                if (hit0 || hit1) begin
                    data_d  = hit0 ? way0[WAY_W-1:DATA_LSB] : way1[WAY_W-1:DATA_LSB];
                    lru_upd = 1'b1;
                    lru_val = hit0;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_MREQ;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MREQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_MWAIT;
                end
            end
            ST_MWAIT: begin
                if (mem_resp_valid) begin
                    data_d  = mem_resp_data;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                sram_ena  = 1'b1;
                sram_wea  = 1'b1;
                sram_wway = victim;
                sram_din  = {data_q, tag, 1'b1};
                lru_upd   = 1'b1;
                lru_val   = ~victim;
                state_d   = ST_RESP;
            end
            default: begin
                state_d     = ST_FLUSH;
                flush_ctr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_FLUSH;
            flush_ctr_q  <= '0;
            line_q       <= '0;
            data_q       <= '0;
            vld_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_ctr_q  <= flush_ctr_d;
            line_q       <= line_d;
            data_q       <= data_d;
            vld_q        <= vld_d;
            flush_pend_q <= flush_pend_d;
        end
    end
endmodule
